// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the arbiter state encoding, the locked-burst length and the data/mask widths.
// No logic lives here beyond a small helper for the burst counter.
package imem_pkg;

    localparam int DATA_W    = 32;
    localparam int MASK_W    = 4;
    localparam int BURST_MAX = 16;
    localparam int BURST_W   = $clog2(BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHARED = 2'd1,
        ST_LOCKED = 2'd2
    } imem_state_t;

    // True when the current locked grant is the last one a burst may take.
    function automatic logic burst_last(input logic [BURST_W-1:0] cnt);
        return cnt == BURST_W'(BURST_MAX - 1);
    endfunction

endpackage

// File: rtl/imem_prio_sel.sv
// Grant selector: loader-priority arbitration with a fetch starvation guard.
// Latency: grants are combinational from requests and the registered starve count.
// Backpressure: the loser of a tie simply sees no grant and keeps requesting.
// Ports: clk/rst_n; locked (arbiter is in a locked burst); f_req/l_req in; f_gnt/l_gnt out.
module imem_prio_sel
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic locked,
    input  logic f_req,
    input  logic l_req,
    output logic f_gnt,
    output logic l_gnt
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == SMAX);

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_n) begin
            if (locked) begin
                // A locked burst owns the memory; the starvation guard is bypassed.
                l_gnt = l_req;
            end else if (l_req && !(f_req && starved)) begin
                l_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
            end
        end
    end

    // Counts loader grants taken while fetch waits; keeps counting during a
    // locked burst so fetch wins the first shared cycle once the burst ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (f_gnt || !f_req) begin
            starve_cnt <= '0;
        end else if (l_gnt && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter sharing one instruction memory between fetch and a loader/debug port.
// Latency: grant and mem_* are combinational; read data returns with rvalid one cycle after grant.
// Backpressure: a requester holds req until it sees its grant; locked loader bursts stall fetch.
// Ports: fetch f_req/f_addr/f_gnt/f_rvalid/f_rdata; loader l_req/l_wr/l_addr/l_wdata/l_mask/
//        l_lock/l_gnt/l_rvalid/l_rdata; memory mem_addr/mem_wdata/mem_wr/mem_mask/mem_rdata.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_wr,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [MASK_W-1:0] l_mask,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic [MASK_W-1:0] mem_mask,
    input  logic [DATA_W-1:0] mem_rdata
);

    imem_state_t        state;
    logic [BURST_W-1:0] burst_cnt;

    imem_prio_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .locked (state == ST_LOCKED),
        .f_req  (f_req),
        .l_req  (l_req),
        .f_gnt  (f_gnt),
        .l_gnt  (l_gnt)
    );

    // Only one grant can be high, so the memory port is a simple select.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_mask  = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_addr = l_addr;
            if (l_wr) begin
                mem_wr    = 1'b1;
                mem_mask  = l_mask;
                mem_wdata = l_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            f_rvalid  <= 1'b0;
            l_rvalid  <= 1'b0;
            f_rdata   <= '0;
            l_rdata   <= '0;
        end else begin
            f_rvalid <= f_gnt;
            if (f_gnt) begin
                f_rdata <= mem_rdata;
            end
            l_rvalid <= l_gnt && !l_wr;
            if (l_gnt && !l_wr) begin
                l_rdata <= mem_rdata;
            end

            case (state)
                ST_IDLE, ST_SHARED: begin
                    if (l_gnt && l_lock) begin
                        // The grant that opens the burst counts as its first.
                        state     <= ST_LOCKED;
                        burst_cnt <= BURST_W'(1);
                    end else if (f_gnt || l_gnt) begin
                        state <= ST_SHARED;
                    end else if (!f_req && !l_req) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (!l_lock || (l_gnt && burst_last(burst_cnt))) begin
                        state     <= ST_SHARED;
                        burst_cnt <= '0;
                    end else if (l_gnt) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, giving the memory word-address width.
REQ-002 The module SHALL have parameter STARVE_MAX, default 4, giving the maximum number of consecutive loader grants while fetch waits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have ports f_req (in, 1), f_addr (in, ADDR_W) and f_gnt (out, 1): the fetch read request, its address and its grant.
REQ-006 The module SHALL have ports f_rvalid (out, 1) and f_rdata (out, 32): the fetch response.
REQ-007 The module SHALL have ports l_req (in, 1), l_wr (in, 1), l_addr (in, ADDR_W), l_wdata (in, 32), l_mask (in, 4), l_lock (in, 1) and l_gnt (out, 1): the loader/debug request, write flag, address, write data, byte-lane mask, burst lock and grant.
REQ-008 The module SHALL have ports l_rvalid (out, 1) and l_rdata (out, 32): the loader read response.
REQ-009 The module SHALL have ports mem_addr (out, ADDR_W), mem_wdata (out, 32), mem_wr (out, 1) and mem_mask (out, 4), which drive the memory; mem_rdata (in, 32) is its combinational read data.

Function
REQ-010 At most one of f_gnt and l_gnt SHALL be high in any cycle; a request completes in the cycle its grant is high.
REQ-011 Grants and mem_* SHALL be combinational from the current requests and the registered state; with no grant, mem_wr=0, mem_mask=0 and mem_addr=0.
REQ-012 The FSM SHALL have states IDLE, SHARED and LOCKED.
REQ-013 In IDLE or SHARED, the loader SHALL win when both request, unless starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-014 starve_cnt SHALL increment on each loader grant while f_req is high.
REQ-015 starve_cnt SHALL clear on any fetch grant or whenever f_req is low, and SHALL saturate at STARVE_MAX.
REQ-016 A loader grant with l_lock=1 SHALL move the FSM to LOCKED.
REQ-017 In LOCKED, only the loader is granted and fetch stalls; starvation is ignored.
REQ-018 The FSM SHALL return to SHARED the cycle after l_lock deasserts, or after 16 locked grants (burst_cnt wrap).
REQ-019 SHARED SHALL return to IDLE when neither requester is active.
REQ-020 A granted read SHALL register mem_rdata into the requester's rdata register and pulse its rvalid high for exactly one cycle, the cycle after the grant (1-cycle latency).
REQ-021 Back-to-back reads SHALL yield rvalid on consecutive cycles.
REQ-022 A granted loader write SHALL drive mem_wr=1 and mem_mask=l_mask, and SHALL produce no l_rvalid.
REQ-023 A write with l_mask=0 SHALL still consume a grant, with mem_wr=1 and no byte changed.
REQ-024 A fetch read granted in the same cycle as a loader write is impossible; reads are always issued after earlier writes, so read-after-write returns the new data.
REQ-025 Addresses SHALL pass through unmodified; no range check or wrap is applied beyond ADDR_W truncation.

Reset
REQ-026 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and starve_cnt and burst_cnt to 0.
REQ-027 While rst_n=0 at a clock edge, f_rvalid and l_rvalid SHALL be 0 and f_rdata and l_rdata SHALL be 32'h0.
REQ-028 While rst_n=0, no grant SHALL be issued and mem_wr=0.
REQ-029 Reset asserted during LOCKED SHALL abandon the burst; a response pending from the previous cycle's grant SHALL be dropped.

Structure
REQ-030 The state enum (IDLE/SHARED/LOCKED), BURST_MAX=16 and mask width 4 SHALL reside in the shared package imem_pkg.
REQ-031 Grant selection with the starvation counter SHALL be one sub-module, imem_prio_sel; the FSM and response registers SHALL stay in imem_arbiter.

Verification
REQ-032 Reset check: hold rst_n=0 for 3 cycles with both requesters active -> no grant, mem_wr=0, both rvalid=0, rdata=0.
REQ-033 Contention: f_req and l_req (read) held continuously -> grant pattern L,L,L,L,F repeating (STARVE_MAX=4); each rvalid one cycle after its grant.
REQ-034 Masked write: loader writes 32'hAABBCCDD to addr 5 with l_mask=4'b0101, then reads addr 5 that held 0 -> l_rdata=32'h00BB00DD.
REQ-035 Lock burst: l_lock=1 for 20 consecutive writes while f_req=1 -> 16 loader grants, fetch granted on the 17th-cycle window, remaining loader writes continue after.
REQ-036 Reset mid-burst: rst_n=0 on the 3rd locked grant -> next cycle the FSM is IDLE, no rvalid, and fetch is granted first after reset if only f_req is active.
REQ-037 Read-after-write: loader writes addr 0x0FF, fetch reads 0x0FF next cycle -> f_rdata equals the written word.
